pipe_stage_elastic: RTL and testbench
=====================================

// Module: pipe_stage_elastic
// PURPOSE
//   Parametrised elastic pipeline-stage register for the pipelined core. It is the successor to the fixed
//   4-field stage latches: it carries NUM_CH packed channels of DATA_W bits each.
//   Adds a valid/ready handshake, a 2-entry skid buffer (full throughput, registered in_ready), flush, and
//   bubble insertion. One instance goes between each pair of stages (IF/ID ... MA/WB).
// PARAMETERS
//   DATA_W     32             width of one channel
//   NUM_CH     4              number of channels (e.g. ALU result, PC+4, read data, instruction)
//   INSTR_CH   3              channel index holding the instruction word; bubble value there is NOP_INSTR
//   NOP_INSTR  32'h0000_0013  bubble instruction (addi x0,x0,0); width DATA_W
// PORTS
//   clk        in   1               rising-edge clock
//   rst        in   1               synchronous reset, active-high
//   flush      in   1               synchronous flush: discard both entries and any same-cycle input
//   in_valid   in   1               upstream payload valid
//   in_ready   out  1               stage can accept; equals (state != TWO) & ~rst, no path from out_ready
//   in_data    in   NUM_CH*DATA_W   packed payload; channel k = in_data[k*DATA_W +: DATA_W]
//   out_valid  out  1               main entry holds valid payload
//   out_ready  in   1               downstream accepts
//   out_data   out  NUM_CH*DATA_W   main-entry payload, same packing
//   occupancy  out  2               entries held: 0, 1 or 2
// BEHAVIOUR
//   - Bubble: all channels 0 except INSTR_CH = NOP_INSTR.
//   - Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. A transfer occurs
//     only on a fire.
//   - Storage: main register (drives out_data), skid register, state in {EMPTY=0, ONE=1, TWO=2}.
//     occupancy = state.
//   - Priority each cycle: rst > flush > normal transitions.
//   - Reset (rst=1 at edge): state EMPTY, out_valid 0, main and skid = bubble, occupancy 0.
//     in_ready is 0 while rst is high and 1 in the first cycle after release.
//   - Flush (flush=1, rst=0): same end state as reset. The same-cycle input is dropped even if
//     in_valid=1, and the same-cycle out_fire still counts downstream. in_ready is not gated by flush.
//   - Transitions with no flush:
//       EMPTY: in_fire -> ONE, main<=in_data; else stay EMPTY.
//       ONE:   in_fire & out_fire -> ONE, main<=in_data.
//              in_fire only -> TWO, skid<=in_data.
//              out_fire only -> EMPTY, main<=bubble.
//              neither -> hold.
//       TWO:   in_ready=0, so no input is taken.
//              out_fire -> ONE, main<=skid, skid<=bubble; else hold.
//   - Latency: 1 cycle from in_fire to out_valid when EMPTY. Sustained throughput: 1 transfer/cycle.
//   - Stability: while out_valid & ~out_ready, out_data and out_valid hold unchanged.
//   - Order: FIFO order is always preserved; no payload is dropped or duplicated except by rst or flush.
//   - Empty output: when out_valid=0, out_data equals the bubble, so downstream sees a NOP without gating.
//   - in_data with in_valid=0 is never captured.
// TESTING
//   1. Reset: drive rst=1 for 2 cycles with in_valid=1, then release.
//      -> out_valid=0 and occupancy=0 throughout reset.
//      -> out_data[INSTR_CH]=32'h13, other channels 0; in_ready=1 the cycle after release.
//   2. Streaming: out_ready=1, send 8 beats (ch0=i, ch3=32'h100+i), one per cycle.
//      -> out_valid rises 1 cycle after the first beat; beats emerge in order, back-to-back.
//      -> occupancy stays at 1 or below.
//   3. Backpressure: out_ready=0, send A then B.
//      -> occupancy 1 then 2; in_ready=0 after B; out_data=A held stable.
//      -> Raise out_ready: A, then B, then bubble; occupancy 2->1->0.
//   4. Flush when full: hold state TWO, pulse flush with in_valid=1 carrying C.
//      -> next cycle occupancy=0, out_valid=0, out_data=bubble; C never appears at the output.
//   5. Flush with simultaneous out_fire in ONE: the held beat counts as delivered in that cycle
//      and state becomes EMPTY.
//   6. Random stall: random in_valid/out_ready for 10k cycles with NUM_CH=2, DATA_W=16.
//      -> Scoreboard: output equals input order with no loss.
//      -> Assert: in_ready is never 1 in TWO; out_data is stable while stalled.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: NUM_CH packed channels, valid/ready handshake,
// 2-entry skid buffer, synchronous flush, and NOP bubble when empty.
module pipe_stage_elastic #(
    parameter int                DATA_W    = 32,
    parameter int                NUM_CH    = 4,
    parameter int                INSTR_CH  = 3,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [1:0]               occupancy
);

    localparam int W = NUM_CH * DATA_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   main_reg, main_next;
    logic [W-1:0]   skid_reg, skid_next;
    logic [W-1:0]   bubble;
    logic           in_fire;
    logic           out_fire;

    // Bubble is all-zero except the instruction channel, which carries a NOP.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_bubble
            if (gi == INSTR_CH) begin : g_nop
                assign bubble[gi*DATA_W +: DATA_W] = NOP_INSTR;
            end else begin : g_zero
                assign bubble[gi*DATA_W +: DATA_W] = '0;
            end
        end
    endgenerate

    // in_ready depends only on stored state and rst, never on out_ready.
    assign in_ready  = (state_reg != TWO) & ~rst;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_reg;
    assign occupancy = state_reg;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (flush) begin
            state_next = EMPTY;
            main_next  = bubble;
            skid_next  = bubble;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = ONE;
                        main_next  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_next = in_data;
                    end else if (in_fire) begin
                        state_next = TWO;
                        skid_next  = in_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                        main_next  = bubble;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_next = ONE;
                        main_next  = skid_reg;
                        skid_next  = bubble;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = bubble;
                    skid_next  = bubble;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= EMPTY;
            main_reg  <= bubble;
            skid_reg  <= bubble;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: directed tests on a 4x32 stage and a
// random-stall run on a 2x16 stage, with per-cycle protocol checks in the monitors.
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 4 x 32 instance
    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;

    // 2 x 16 instance, instruction in channel 1
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0]  b_in_data, b_out_data;
    logic [1:0]   b_occ;

    localparam logic [127:0] BUBBLE_A = {32'h0000_0013, 32'h0, 32'h0, 32'h0};
    localparam logic [31:0]  BUBBLE_B = {16'h0013, 16'h0000};

    pipe_stage_elastic #(.DATA_W(32), .NUM_CH(4), .INSTR_CH(3), .NOP_INSTR(32'h0000_0013)) dut_a (
        .clk(clk), .rst(rst), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_elastic #(.DATA_W(16), .NUM_CH(2), .INSTR_CH(1), .NOP_INSTR(16'h0013)) dut_b (
        .clk(clk), .rst(rst), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    int total = 0;
    int bad   = 0;
    logic [127:0] qa[$];
    logic [31:0]  qb[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] beat(input logic [31:0] c0, input logic [31:0] c3);
        return {c3, 32'h0, 32'h0, c0};
    endfunction

    // One clock: record accepted inputs in the scoreboard at the sampling edge,
    // then return just after the active edge so the caller can drive/check.
    task automatic tick();
        @(negedge clk);
        if (!rst && !a_flush && a_in_valid && a_in_ready) qa.push_back(a_in_data);
        if (!rst && !b_flush && b_in_valid && b_in_ready) qb.push_back(b_in_data);
        @(posedge clk);
        #1;
    endtask

    // Monitor for instance A
    logic         a_prev_stall = 1'b0;
    logic [127:0] a_prev_data;
    always @(negedge clk) begin
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_out", a_out_data, BUBBLE_A);
            end else begin
                logic [127:0] e;
                e = qa.pop_front();
                chk("a_out_data", a_out_data, e);
                $display("a out ch0=%h ch3=%h", a_out_data[31:0], a_out_data[127:96]);
            end
        end
        if (!a_out_valid) chk("a_idle_bubble", a_out_data, BUBBLE_A);
        if (a_occ == 2'd2) chk("a_ready_in_two", {127'b0, a_in_ready}, 128'd0);
        if (a_prev_stall) begin
            chk("a_stall_data", a_out_data, a_prev_data);
            chk("a_stall_valid", {127'b0, a_out_valid}, 128'd1);
        end
        a_prev_stall = a_out_valid && !a_out_ready && !a_flush && !rst;
        a_prev_data  = a_out_data;
        if (a_flush || rst) qa.delete();
    end

    // Monitor for instance B
    logic        b_prev_stall = 1'b0;
    logic [31:0] b_prev_data;
    always @(negedge clk) begin
        if (b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_out", {96'b0, b_out_data}, {96'b0, BUBBLE_B});
            end else begin
                logic [31:0] e;
                e = qb.pop_front();
                chk("b_out_data", {96'b0, b_out_data}, {96'b0, e});
                $display("b out %h", b_out_data);
            end
        end
        if (!b_out_valid) chk("b_idle_bubble", {96'b0, b_out_data}, {96'b0, BUBBLE_B});
        if (b_occ == 2'd2) chk("b_ready_in_two", {127'b0, b_in_ready}, 128'd0);
        if (b_prev_stall) begin
            chk("b_stall_data", {96'b0, b_out_data}, {96'b0, b_prev_data});
            chk("b_stall_valid", {127'b0, b_out_valid}, 128'd1);
        end
        b_prev_stall = b_out_valid && !b_out_ready && !b_flush && !rst;
        b_prev_data  = b_out_data;
        if (b_flush || rst) qb.delete();
    end

    initial begin
        rst = 1'b1;
        a_flush = 1'b0; a_in_valid = 1'b1; a_in_data = beat(32'hDEAD, 32'hBEEF); a_out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b1; b_in_data = 32'h1234_5678;          b_out_ready = 1'b0;

        // 1. Reset for two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_out_valid", {127'b0, a_out_valid}, 128'd0);
            chk("rst_occ", {126'b0, a_occ}, 128'd0);
            chk("rst_in_ready", {127'b0, a_in_ready}, 128'd0);
        end
        rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;
        #1;
        chk("rel_in_ready", {127'b0, a_in_ready}, 128'd1);
        chk("rel_out_data", a_out_data, BUBBLE_A);
        chk("rel_b_out_data", {96'b0, b_out_data}, {96'b0, BUBBLE_B});

        // 2. Streaming with out_ready high
        a_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = beat(32'(i), 32'h100 + 32'(i));
            tick();
            chk("stream_valid", {127'b0, a_out_valid}, 128'd1);
            chk("stream_data", a_out_data, beat(32'(i), 32'h100 + 32'(i)));
            chk("stream_occ", {126'b0, a_occ}, 128'd1);
        end
        a_in_valid = 1'b0;
        tick();
        chk("stream_drain_valid", {127'b0, a_out_valid}, 128'd0);

        // 3. Backpressure: A then B, then release
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = beat(32'hA, 32'hAAAA);
        tick();
        chk("bp_occ1", {126'b0, a_occ}, 128'd1);
        chk("bp_ready1", {127'b0, a_in_ready}, 128'd1);
        a_in_data = beat(32'hB, 32'hBBBB);
        tick();
        chk("bp_occ2", {126'b0, a_occ}, 128'd2);
        chk("bp_ready2", {127'b0, a_in_ready}, 128'd0);
        chk("bp_hold_a", a_out_data, beat(32'hA, 32'hAAAA));
        a_in_valid = 1'b0;
        tick();
        chk("bp_hold_a2", a_out_data, beat(32'hA, 32'hAAAA));
        a_out_ready = 1'b1;
        tick();
        chk("bp_then_b", a_out_data, beat(32'hB, 32'hBBBB));
        chk("bp_occ_1", {126'b0, a_occ}, 128'd1);
        tick();
        chk("bp_then_bubble", a_out_data, BUBBLE_A);
        chk("bp_occ_0", {126'b0, a_occ}, 128'd0);

        // 4. Flush in TWO with a same-cycle input C
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = beat(32'h1, 32'h11); tick();
        a_in_data = beat(32'h2, 32'h22); tick();
        chk("fl_full", {126'b0, a_occ}, 128'd2);
        a_flush = 1'b1; a_in_data = beat(32'hC, 32'hCCCC);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("fl_occ", {126'b0, a_occ}, 128'd0);
        chk("fl_valid", {127'b0, a_out_valid}, 128'd0);
        chk("fl_data", a_out_data, BUBBLE_A);
        a_out_ready = 1'b1;
        tick(); tick();

        // Flush in ONE with a stalled output and an incoming D: D must be dropped
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = beat(32'h3, 32'h33); tick();
        a_flush = 1'b1; a_in_data = beat(32'hD, 32'hDDDD); tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("fl1_occ", {126'b0, a_occ}, 128'd0);
        a_out_ready = 1'b1;
        tick(); tick();

        // 5. Flush with simultaneous out_fire in ONE: E delivered, F dropped
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = beat(32'hE, 32'hEEEE); tick();
        a_out_ready = 1'b1; a_flush = 1'b1; a_in_data = beat(32'hF, 32'hFFFF);
        tick();
        a_flush = 1'b0; a_in_valid = 1'b0;
        chk("flo_occ", {126'b0, a_occ}, 128'd0);
        chk("flo_q_empty", 128'(qa.size()), 128'd0);
        tick(); tick(); tick();

        // 6. Random stalls on the 2 x 16 instance
        for (int i = 0; i < 10000; i++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_data   = {16'($urandom), 16'(i)};
            tick();
        end
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        chk("qa_empty_end", 128'(qa.size()), 128'd0);
        chk("qb_empty_end", 128'(qb.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
